// File: rtl/syn_fifo_pkg.sv
// syn_fifo_pkg: shared state encoding and default sizing for the FIFO read controller
package syn_fifo_pkg;
  localparam int FIFO_ENTRIES_DEF = 16;
  localparam int DATA_WIDTH_DEF = 8;
  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} rd_state_t;
endpackage

// File: rtl/syn_fifo_skid.sv
// syn_fifo_skid: 2-entry skid buffer with bypass so a word can pass through in the cycle it arrives
module syn_fifo_skid #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [1:0]            occ
);
  logic [DATA_WIDTH-1:0] d0, d1;
  logic xfer, pop, push;
  // present the oldest stored word, or the arriving word when nothing is stored
  always_comb begin
    s_ready = occ != 2'd2;
    m_valid = occ != 2'd0 || s_valid;
    m_data = occ != 2'd0 ? d0 : (s_valid ? s_data : '0);
    xfer = m_valid && m_ready;
    pop = xfer && occ != 2'd0;
    push = s_valid && !(xfer && occ == 2'd0);
  end
  // d0 is the head; d1 only holds a second word while the head is stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ <= '0;
      d0 <= '0;
      d1 <= '0;
    end else begin
      occ <= occ + {1'b0, push} - {1'b0, pop};
      if ((occ == 2'd0 && push) || pop) d0 <= occ == 2'd2 ? d1 : s_data;
      if (occ == 2'd1 && push && !pop) d1 <= s_data;
    end
  end
endmodule

// File: rtl/syn_fifo_rd_ctrl.sv
// syn_fifo_rd_ctrl: drains a burst of words from a synchronous FIFO into a valid/ready stream
module syn_fifo_rd_ctrl
  import syn_fifo_pkg::*;
#(
  parameter int FIFO_ENTRIES = FIFO_ENTRIES_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  localparam int IDX_W = $clog2(FIFO_ENTRIES),
  localparam int CNT_W = IDX_W + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [CNT_W-1:0]      burst_len_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_rd_en_o,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  input  logic                  m_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [IDX_W-1:0]      r_index_o
);
  rd_state_t state;
  logic [CNT_W-1:0] remaining;
  logic in_flight, s_ready;
  logic [1:0] occ;
  // pop only while the words already owed to the skid buffer leave room for one more
  always_comb begin
    fifo_rd_en_o = state == DRAIN && !fifo_empty_i && remaining != '0 && s_ready
                   && ({1'b0, in_flight} + occ) < 2'd2;
    busy_o = state != IDLE;
    done_o = state == DONE;
  end
  // burst sequencing, remaining count, read pointer mirror and in-flight tracking
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      remaining <= '0;
      in_flight <= 1'b0;
      r_index_o <= '0;
    end else begin
      in_flight <= fifo_rd_en_o;
      case (state)
        IDLE: if (start_i) begin
          remaining <= burst_len_i;
          state <= burst_len_i != '0 ? DRAIN : DONE;
        end
        DRAIN: if (fifo_rd_en_o) begin
          remaining <= remaining - CNT_W'(1);
          r_index_o <= r_index_o + IDX_W'(1);
          if (remaining == CNT_W'(1)) state <= FLUSH;
        end
        FLUSH: if (!in_flight && occ == 2'd0) state <= DONE;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  syn_fifo_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk(clk_i),
    .rst(rst_i),
    .s_valid(in_flight),
    .s_data(fifo_data_i),
    .s_ready(s_ready),
    .m_valid(m_valid_o),
    .m_data(m_data_o),
    .m_ready(m_ready_i),
    .occ(occ)
  );
endmodule

// File: doc/syn_fifo_rd_ctrl.md
SYN_FIFO_RD_CTRL -- requirements
Module: syn_fifo_rd_ctrl

Interface
REQ-001 The block SHALL have parameter FIFO_ENTRIES, default 16, meaning the depth of the attached synchronous FIFO (power of two, >= 2).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, meaning the FIFO word width.
REQ-003 The block SHALL have derived widths IDX_W = $clog2(FIFO_ENTRIES) and CNT_W = IDX_W+1.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-006 The block SHALL have port rst_i, input, 1 bit: the asynchronous active-high reset.
REQ-007 The block SHALL have port start_i, input, 1 bit: a one-cycle burst request.
REQ-008 The block SHALL have port burst_len_i, input, CNT_W bits: the number of words to drain, sampled when start_i is accepted.
REQ-009 The block SHALL have port fifo_empty_i, input, 1 bit: the empty flag of the FIFO.
REQ-010 The block SHALL have port fifo_data_i, input, DATA_WIDTH bits: FIFO read data, valid exactly 1 cycle after fifo_rd_en_o.
REQ-011 The block SHALL have port fifo_rd_en_o, output, 1 bit: the FIFO pop strobe.
REQ-012 The block SHALL have port m_valid_o, output, 1 bit: downstream data valid.
REQ-013 The block SHALL have port m_data_o, output, DATA_WIDTH bits: downstream data.
REQ-014 The block SHALL have port m_ready_i, input, 1 bit: downstream ready.
REQ-015 The block SHALL have port busy_o, output, 1 bit: high when the state is not IDLE.
REQ-016 The block SHALL have port done_o, output, 1 bit: a one-cycle pulse at burst completion.
REQ-017 The block SHALL have port r_index_o, output, IDX_W bits: a mirror of the FIFO read pointer.

Function
REQ-018 The FSM SHALL have the states IDLE, DRAIN, FLUSH and DONE.
REQ-019 In IDLE, start_i=1 with burst_len_i!=0 SHALL latch remaining=burst_len_i and move the FSM to DRAIN.
REQ-020 In IDLE, start_i=1 with burst_len_i=0 SHALL move the FSM to DONE and issue no pops.
REQ-021 start_i SHALL be ignored in every state other than IDLE.
REQ-022 fifo_rd_en_o SHALL be high only when all of the following hold: the state is DRAIN, fifo_empty_i=0, remaining!=0, and (words in flight + words held in the skid buffer) < 2.
REQ-023 fifo_rd_en_o SHALL be combinational from registered state and fifo_empty_i, and SHALL never depend on m_ready_i.
REQ-024 Each pop SHALL decrement remaining by 1 and advance r_index_o by 1, wrapping from FIFO_ENTRIES-1 to 0.
REQ-025 When the last pop issues (remaining goes 1->0), the FSM SHALL move from DRAIN to FLUSH.
REQ-026 In FLUSH, once nothing is in flight, the skid buffer is empty and no handshake is pending, the FSM SHALL move to DONE.
REQ-027 DONE SHALL last exactly 1 cycle with done_o=1, then return to IDLE.
REQ-028 Data returning from the FIFO SHALL be captured into a 2-entry skid buffer and presented in pop order.
REQ-029 m_valid_o SHALL be high whenever the skid buffer is non-empty.
REQ-030 A transfer SHALL occur when m_valid_o=1 and m_ready_i=1 on the same edge.
REQ-031 While m_valid_o=1 and m_ready_i=0, m_data_o SHALL hold stable and m_valid_o SHALL stay high.
REQ-032 With m_ready_i held at 1 and a non-empty FIFO, the block SHALL sustain one word per cycle after a 2-cycle initial latency (start_i to first m_valid_o).
REQ-033 If fifo_empty_i=1 during DRAIN, the block SHALL stall pops, keep its state and remaining count, and resume when the FIFO becomes non-empty; there is no timeout.
REQ-034 The skid buffer SHALL never overflow and no word SHALL be dropped or duplicated under any m_ready_i pattern.
REQ-035 A simultaneous capture and transfer in the same cycle SHALL leave the skid occupancy unchanged.

Reset
REQ-036 Asserting rst_i SHALL, asynchronously, set the FSM to IDLE, clear remaining, the in-flight flag, skid occupancy and r_index_o, and drive fifo_rd_en_o=0, m_valid_o=0, m_data_o=0, busy_o=0 and done_o=0.
REQ-037 Reset asserted mid-burst SHALL discard in-flight and buffered words; the FIFO is reset by the same rst_i, so pointers stay aligned.
REQ-038 After rst_i deasserts, no pop SHALL occur until a new start_i.

Structure
REQ-039 The package syn_fifo_pkg SHALL hold the FSM state enum rd_state_t and the defaults for FIFO_ENTRIES and DATA_WIDTH.
REQ-040 The 2-entry skid buffer SHALL be a sub-module named syn_fifo_skid (valid/ready in, valid/ready out, occupancy output); the FSM, pop credit logic and counters SHALL live in the top module.

Verification
REQ-041 FIFO preloaded with 16 words, burst_len_i=16, m_ready_i=1 -> 16 pops on consecutive cycles, data out in order, done_o pulses once, r_index_o=0 after wrap.
REQ-042 8 words preloaded, burst_len_i=8, m_ready_i toggling 1/0 every cycle -> 8 ordered words with no loss or duplicate, fifo_rd_en_o never asserted with 2 words outstanding.
REQ-043 burst_len_i=0 -> done_o high 1 cycle after start_i, fifo_rd_en_o never asserted, r_index_o unchanged.
REQ-044 FIFO empty at start, burst_len_i=4, words pushed 10 cycles later -> the block waits in DRAIN with busy_o=1, then delivers all 4 words.
REQ-045 rst_i asserted after 5 of 16 words in a 16-word burst -> all outputs return to reset values in the same cycle; a new 16-word burst then completes correctly with r_index_o restarting at 0.
REQ-046 start_i pulsed during DRAIN -> ignored; exactly burst_len words are popped and done_o pulses once.
